// File: rtl/qacc_collector.sv
// ============================================================================
//  Module      : qacc_collector
//  Description : Sums valid beats lane by lane until a beat marked last, then
//                queues the result in a show-ahead FIFO for a valid/ready reader.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module qacc_collector #(
  parameter int RANK_FACTOR_MATRIX = 16,
  parameter int N                  = 32,
  parameter int FIFO_DEPTH         = 4,
  parameter int CNT_W              = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          in_avl,
  input  logic                          in_last,
  input  logic [RANK_FACTOR_MATRIX*N-1:0] in_vec,
  output logic                          out_avl,
  input  logic                          out_rdy,
  output logic [RANK_FACTOR_MATRIX*N-1:0] out_vec,
  output logic [CNT_W-1:0]              out_beats,
  output logic                          almost_full,
  output logic                          overflow,
  output logic [CNT_W-1:0]              drop_cnt
);

  localparam int c_VW     = RANK_FACTOR_MATRIX * N;
  localparam int c_PTR_W  = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int c_CNT_FW = c_PTR_W + 1;
  localparam logic [c_CNT_FW-1:0] c_DEPTH   = c_CNT_FW'(FIFO_DEPTH);
  localparam logic [c_CNT_FW-1:0] c_AF_LVL  = c_CNT_FW'(FIFO_DEPTH - 1);
  localparam logic [CNT_W-1:0]    c_CNT_MAX = {CNT_W{1'b1}};

  logic [c_VW-1:0]     acc_q, acc_d;
  logic                open_q, open_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [c_VW-1:0]     mem_vec_q   [FIFO_DEPTH];
  logic [CNT_W-1:0]    mem_beats_q [FIFO_DEPTH];
  logic [c_PTR_W-1:0]  wr_ptr_q, rd_ptr_q;
  logic [c_CNT_FW-1:0] count_q, count_d;
  logic                af_q, ovf_q;
  logic [CNT_W-1:0]    drop_q;

  logic [c_VW-1:0]     w_sum;
  logic [CNT_W-1:0]    w_base_cnt, w_beats;
  logic                w_push, w_pop, w_push_ok, w_drop;

  // Each lane wraps independently; carries never cross lane boundaries.
  for (genvar j = 0; j < RANK_FACTOR_MATRIX; j++) begin : g_lane
    assign w_sum[j*N +: N] = (open_q ? acc_q[j*N +: N] : {N{1'b0}}) + in_vec[j*N +: N];
  end

  assign w_base_cnt = open_q ? cnt_q : {CNT_W{1'b0}};
  assign w_beats    = (w_base_cnt == c_CNT_MAX) ? c_CNT_MAX : w_base_cnt + CNT_W'(1);

  assign out_avl     = (count_q != {c_CNT_FW{1'b0}});
  assign out_vec     = mem_vec_q[rd_ptr_q];
  assign out_beats   = mem_beats_q[rd_ptr_q];
  assign almost_full = af_q;
  assign overflow    = ovf_q;
  assign drop_cnt    = drop_q;

  assign w_push    = in_avl & in_last;
  assign w_pop     = out_avl & out_rdy;
  assign w_push_ok = w_push & ((count_q < c_DEPTH) | w_pop);
  assign w_drop    = w_push & ~w_push_ok;

  always_comb begin
    acc_d   = acc_q;
    open_d  = open_q;
    cnt_d   = cnt_q;
    count_d = count_q;
    if (in_avl) begin
      if (in_last) begin
        acc_d  = {c_VW{1'b0}};
        open_d = 1'b0;
        cnt_d  = {CNT_W{1'b0}};
      end else begin
        acc_d  = w_sum;
        open_d = 1'b1;
        cnt_d  = w_beats;
      end
    end
    case ({w_push_ok, w_pop})
      2'b10:   count_d = count_q + c_CNT_FW'(1);
      2'b01:   count_d = count_q - c_CNT_FW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q    <= {c_VW{1'b0}};
      open_q   <= 1'b0;
      cnt_q    <= {CNT_W{1'b0}};
      wr_ptr_q <= {c_PTR_W{1'b0}};
      rd_ptr_q <= {c_PTR_W{1'b0}};
      count_q  <= {c_CNT_FW{1'b0}};
      af_q     <= 1'b0;
      ovf_q    <= 1'b0;
      drop_q   <= {CNT_W{1'b0}};
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_vec_q[i]   <= {c_VW{1'b0}};
        mem_beats_q[i] <= {CNT_W{1'b0}};
      end
    end else begin
      acc_q   <= acc_d;
      open_q  <= open_d;
      cnt_q   <= cnt_d;
      count_q <= count_d;
      af_q    <= (count_d >= c_AF_LVL);
      if (w_push_ok) begin
        mem_vec_q[wr_ptr_q]   <= w_sum;
        mem_beats_q[wr_ptr_q] <= w_beats;
        wr_ptr_q              <= wr_ptr_q + c_PTR_W'(1);
      end
      if (w_pop) begin
        rd_ptr_q <= rd_ptr_q + c_PTR_W'(1);
      end
      // A dropped result still closes its group (accumulator cleared above).
      if (w_drop) begin
        ovf_q <= 1'b1;
        if (drop_q != c_CNT_MAX) begin
          drop_q <= drop_q + CNT_W'(1);
        end
      end
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_qacc_collector.sv
// ============================================================================
//  Module      : tb_qacc_collector
//  Description : Directed scoreboard bench for qacc_collector.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_qacc_collector;

  localparam int R  = 16;
  localparam int NW = 32;
  localparam int VW = R * NW;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_avl, in_last, out_rdy;
  logic [VW-1:0] in_vec;
  logic          out_avl, almost_full, overflow;
  logic [VW-1:0] out_vec;
  logic [CW-1:0] out_beats, drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  logic [VW-1:0] exp_vec_q   [$];
  logic [CW-1:0] exp_beats_q [$];

  qacc_collector #(
    .RANK_FACTOR_MATRIX(R), .N(NW), .FIFO_DEPTH(4), .CNT_W(CW)
  ) dut (
    .clk(clk), .rst(rst), .in_avl(in_avl), .in_last(in_last), .in_vec(in_vec),
    .out_avl(out_avl), .out_rdy(out_rdy), .out_vec(out_vec), .out_beats(out_beats),
    .almost_full(almost_full), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [VW-1:0] fill(input logic [NW-1:0] val);
    logic [VW-1:0] v;
    for (int j = 0; j < R; j++) v[j*NW +: NW] = val;
    return v;
  endfunction

  task automatic chk(input string name, input logic [VW-1:0] act, input logic [VW-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic expect_result(input logic [VW-1:0] v, input logic [CW-1:0] b);
    exp_vec_q.push_back(v);
    exp_beats_q.push_back(b);
  endtask

  // Drive one beat for one clock; caller sits just after a rising edge.
  task automatic send(input logic [VW-1:0] v, input logic last);
    in_avl  = 1'b1;
    in_last = last;
    in_vec  = v;
    @(posedge clk); #1;
    in_avl  = 1'b0;
    in_last = 1'b0;
    in_vec  = '0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
    end
  endtask

  // Monitor: every accepted head is compared against the next expected result.
  always @(negedge clk) begin
    if (!rst && out_avl && out_rdy) begin
      if (exp_vec_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %0h beats %0d expected none", out_vec, out_beats);
      end else begin
        logic [VW-1:0] ev;
        logic [CW-1:0] eb;
        ev = exp_vec_q.pop_front();
        eb = exp_beats_q.pop_front();
        chk("out_vec", out_vec, ev);
        chk("out_beats", VW'(out_beats), VW'(eb));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [VW-1:0] v1, v2, ve;
    rst = 1'b1; in_avl = 1'b0; in_last = 1'b0; in_vec = '0; out_rdy = 1'b1;
    idle(3);
    rst = 1'b0;
    idle(5);
    chk("reset_out_avl",     VW'(out_avl),     VW'(0));
    chk("reset_almost_full", VW'(almost_full), VW'(0));
    chk("reset_overflow",    VW'(overflow),    VW'(0));
    chk("reset_drop_cnt",    VW'(drop_cnt),    VW'(0));
    chk("reset_out_vec",     out_vec,          '0);
    chk("reset_out_beats",   VW'(out_beats),   VW'(0));

    // Three-beat group: 1+2+3 = 6 on every lane, one-cycle latency.
    expect_result(fill(32'd6), 16'd3);
    send(fill(32'd1), 1'b0);
    send(fill(32'd2), 1'b0);
    send(fill(32'd3), 1'b1);
    chk("latency_out_avl", VW'(out_avl), VW'(1));
    idle(1);
    chk("drained_out_avl", VW'(out_avl), VW'(0));

    // Lane 0 wraps, other lanes double their index.
    for (int j = 0; j < R; j++) begin
      v1[j*NW +: NW] = NW'(j);
      v2[j*NW +: NW] = NW'(j);
      ve[j*NW +: NW] = NW'(2 * j);
    end
    v1[NW-1:0] = 32'hFFFF_FFFF;
    v2[NW-1:0] = 32'h0000_0002;
    ve[NW-1:0] = 32'h0000_0001;
    expect_result(ve, 16'd2);
    send(v1, 1'b0);
    send(v2, 1'b1);
    idle(2);

    // Fill with out_rdy low, fifth result dropped.
    out_rdy = 1'b0;
    for (int k = 10; k <= 14; k++) begin
      if (k <= 13) expect_result(fill(NW'(k)), 16'd1);
      send(fill(NW'(k)), 1'b1);
      if (k == 11) chk("af_after_2_pushes", VW'(almost_full), VW'(0));
      if (k == 12) chk("af_after_3_pushes", VW'(almost_full), VW'(1));
    end
    chk("overflow_after_drop", VW'(overflow), VW'(1));
    chk("drop_cnt_after_drop", VW'(drop_cnt), VW'(1));
    chk("full_out_avl",        VW'(out_avl),  VW'(1));
    out_rdy = 1'b1;
    idle(4);
    chk("drain_out_avl",     VW'(out_avl),     VW'(0));
    chk("drain_almost_full", VW'(almost_full), VW'(0));

    // Refill, then push while popping a full FIFO.
    out_rdy = 1'b0;
    for (int k = 20; k <= 23; k++) begin
      expect_result(fill(NW'(k)), 16'd1);
      send(fill(NW'(k)), 1'b1);
    end
    expect_result(fill(32'd99), 16'd1);
    out_rdy = 1'b1;
    send(fill(32'd99), 1'b1);
    out_rdy = 1'b0;
    chk("pushpop_drop_cnt", VW'(drop_cnt),    VW'(1));
    chk("pushpop_af",       VW'(almost_full), VW'(1));
    chk("pushpop_out_avl",  VW'(out_avl),     VW'(1));
    out_rdy = 1'b1;
    idle(5);
    chk("pushpop_drained", VW'(out_avl), VW'(0));

    // Reset mid-group discards the partial sum and clears sticky status.
    send(fill(32'd5), 1'b0);
    send(fill(32'd5), 1'b0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    chk("rst2_overflow", VW'(overflow), VW'(0));
    chk("rst2_drop_cnt", VW'(drop_cnt), VW'(0));
    chk("rst2_out_avl",  VW'(out_avl),  VW'(0));
    expect_result(fill(32'd7), 16'd1);
    send(fill(32'd7), 1'b1);
    idle(3);

    chk("scoreboard_empty", VW'(exp_vec_q.size()), VW'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/qacc_collector.md
Name: qacc_collector

Overview:
- Sink-side partner of the element-wise vector adder stage. It consumes that stage's valid-qualified stream of RANK_FACTOR_MATRIX-wide result vectors.
- It accumulates beats element-wise until a beat marked last, then queues the reduced vector in a small result FIFO.
- It presents the queued vectors to the downstream writer with a valid/ready handshake.
- The upstream adder has no backpressure input, so the block raises an almost-full flag for upstream gating. It records any result it has to drop.

Parameters:
- RANK_FACTOR_MATRIX, 16, number of lanes per vector.
- N, 32, lane width in bits (two's-complement, wrap-around arithmetic).
- FIFO_DEPTH, 4, result FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the beat counter and the drop counter.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- in_avl  in  1  input beat valid; no ready is returned, so every beat with in_avl=1 is consumed.
- in_last  in  1  beat closes the current group; ignored when in_avl=0.
- in_vec  in  RANK_FACTOR_MATRIX*N  input vector, lane j at bits [j*N +: N].
- out_avl  out  1  head of the result FIFO is valid.
- out_rdy  in  1  downstream accepts the head.
- out_vec  out  RANK_FACTOR_MATRIX*N  reduced vector at the FIFO head.
- out_beats  out  CNT_W  number of beats summed into out_vec (saturating).
- almost_full  out  1  FIFO count >= FIFO_DEPTH-1.
- overflow  out  1  sticky: at least one result was dropped.
- drop_cnt  out  CNT_W  number of dropped results (saturating).

Behaviour:
- Reset: clk and rst only; rst is synchronous and active-high.
  - Reset values: accumulator 0, group-open flag 0, beat counter 0, FIFO pointers and count 0, out_avl 0, out_vec 0, out_beats 0, almost_full 0, overflow 0, drop_cnt 0.
  - Reset asserted mid-group discards the partial sum. Reset discards all queued results.
- Accumulate: on a cycle with in_avl=1, compute sum = (group open ? acc : 0) + in_vec.
  - Addition is per lane, N-bit modulo (carry out discarded). Lanes are independent.
  - Beats = (group open ? cnt : 0) + 1, saturating at 2^CNT_W-1.
- Non-last beat (in_avl=1, in_last=0): acc <= sum, cnt <= beats, group open <= 1.
- Last beat (in_avl=1, in_last=1): {sum, beats} is written to the FIFO tail. acc, cnt and group-open are all cleared.
  - A single beat with in_last=1 forms a one-beat group.
- FIFO:
  - Show-ahead. out_avl = (count != 0). out_vec and out_beats reflect the head entry; they are registered storage, not combinational from inputs.
  - out_vec and out_beats hold stable while out_avl=1 and out_rdy=0.
  - Pop occurs when out_avl && out_rdy.
- Latency: a last beat at cycle t gives out_avl=1 at t+1 when the FIFO was empty. Total latency from the last beat to out_avl is 1 cycle.
- Push allowance: a push is allowed if count < FIFO_DEPTH, or if a pop occurs in the same cycle.
  - Full + push + pop: the entry is accepted and count is unchanged.
  - Empty + push: out_avl rises next cycle. There is no same-cycle bypass.
- Overflow: a push that is not allowed drops the result and still clears the accumulator.
  - overflow <= 1 (cleared only by reset). drop_cnt increments, saturating.
- almost_full is registered from the next count value. Upstream must stop issuing last beats while it is high.
- Pointers wrap modulo FIFO_DEPTH.
- in_avl=0 leaves the accumulator untouched, so gaps inside a group are allowed.

Test Plan:
- Reset, then idle for 5 cycles -> out_avl=0, almost_full=0, overflow=0, drop_cnt=0.
- Three beats with all lanes = 1, 2, 3 (last on the third), out_rdy=1 -> one cycle after the third beat, out_avl=1, every lane = 6, out_beats=3. out_avl=0 on the following cycle.
- Lane 0 = 0xFFFFFFFF then 0x00000002 (last), other lanes = lane index -> lane 0 = 0x00000001 (wrap), lane j = 2j, out_beats=2.
- out_rdy=0, five one-beat groups with values 10..14, FIFO_DEPTH=4:
  - almost_full rises after the third push.
  - The fifth result is dropped: overflow=1, drop_cnt=1.
  - Then out_rdy=1 -> outputs 10, 11, 12, 13 in order.
- FIFO full, same-cycle pop and last beat with value 99 -> no drop, count stays 4, and 99 later emerges after the three older entries.
- Two non-last beats of value 5, then rst=1 for 1 cycle, then one last beat of value 7 -> result 7 with out_beats=1, and no earlier result is emitted.
